// File: rtl/sub_result_bcd_converter.sv
// Converts the subtractor result to sign plus three BCD digits
// using a sequential double-dabble with a valid/ready handshake.
module sub_result_bcd_converter #(
   parameter bit SIGNED_MODE = 1'b0,
   parameter bit ZERO_BLANK  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] DiffIn,
   input  logic       BorrowIn,
   input  logic       InValid,
   output logic       InReady,
   output logic       Negative,
   output logic [3:0] Hundreds,
   output logic [3:0] Tens,
   output logic [3:0] Ones,
   output logic       OutValid,
   input  logic       OutReady,
   output logic       Busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, nextState;

   logic [7:0]  magReg;
   logic [11:0] bcdReg;
   logic [2:0]  count;
   logic        signReg;

   logic        accSign;
   logic [7:0]  accMag;
   logic [11:0] bcdAdj;
   logic [19:0] shifted;
   logic [3:0]  hDig, tDig, oDig;
   logic [3:0]  hOut, tOut;

   always_comb begin
      accSign = SIGNED_MODE ? DiffIn[7] : BorrowIn;
      accMag  = accSign ? (~DiffIn + 8'd1) : DiffIn;
   end

   // Add-3 correction on every nibble before each shift
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         bcdAdj[i*4 +: 4] = (bcdReg[i*4 +: 4] >= 4'd5)
                          ? bcdReg[i*4 +: 4] + 4'd3
                          : bcdReg[i*4 +: 4];
      end
      shifted = {bcdAdj[10:0], magReg, 1'b0};
      hDig = shifted[19:16];
      tDig = shifted[15:12];
      oDig = shifted[11:8];
      hOut = (ZERO_BLANK && hDig == 4'd0) ? 4'hF : hDig;
      tOut = (ZERO_BLANK && hDig == 4'd0 && tDig == 4'd0)
           ? 4'hF : tDig;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: if (InValid) nextState = CONV;
         CONV: if (count == 3'd7) nextState = DONE;
         DONE: if (OutReady) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      InReady  = (state == IDLE);
      Busy     = (state == CONV);
      OutValid = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         magReg   <= '0;
         bcdReg   <= '0;
         count    <= '0;
         signReg  <= 1'b0;
         Negative <= 1'b0;
         Hundreds <= '0;
         Tens     <= '0;
         Ones     <= '0;
      end else begin
         if (state == IDLE && InValid) begin
            magReg  <= accMag;
            bcdReg  <= '0;
            count   <= '0;
            // a zero magnitude is never reported as negative
            signReg <= accSign && (accMag != 8'd0);
         end else if (state == CONV) begin
            magReg <= shifted[7:0];
            bcdReg <= shifted[19:8];
            count  <= count + 3'd1;
            if (count == 3'd7) begin
               Negative <= signReg;
               Hundreds <= hOut;
               Tens     <= tOut;
               Ones     <= oDig;
            end
         end
      end
   end

endmodule

// File: tb/tb_sub_result_bcd_converter.sv
// Directed bench for sub_result_bcd_converter, unsigned and
// signed instances driven in parallel from a vector table.
module tb_sub_result_bcd_converter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] DiffIn;
   logic       BorrowIn;
   logic       InValid;
   logic       OutReady;

   logic       uInReady, uNeg, uOutValid, uBusy;
   logic [3:0] uH, uT, uO;
   logic       sInReady, sNeg, sOutValid, sBusy;
   logic [3:0] sH, sT, sO;

   int nChecks = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   sub_result_bcd_converter #(.SIGNED_MODE(1'b0), .ZERO_BLANK(1'b1)) dutU (
      .clk(clk), .rst_n(rst_n), .DiffIn(DiffIn), .BorrowIn(BorrowIn),
      .InValid(InValid), .InReady(uInReady), .Negative(uNeg),
      .Hundreds(uH), .Tens(uT), .Ones(uO), .OutValid(uOutValid),
      .OutReady(OutReady), .Busy(uBusy)
   );

   sub_result_bcd_converter #(.SIGNED_MODE(1'b1), .ZERO_BLANK(1'b1)) dutS (
      .clk(clk), .rst_n(rst_n), .DiffIn(DiffIn), .BorrowIn(BorrowIn),
      .InValid(InValid), .InReady(sInReady), .Negative(sNeg),
      .Hundreds(sH), .Tens(sT), .Ones(sO), .OutValid(sOutValid),
      .OutReady(OutReady), .Busy(sBusy)
   );

   typedef struct {
      logic [7:0] diff;
      logic       borrow;
      logic       un;
      logic [3:0] uh, ut, uo;
      logic       sn;
      logic [3:0] sh, st, so;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chkOut(input string nm, input vec_t v);
      chk({nm, " uNeg"}, uNeg, v.un);
      chk({nm, " uDig"}, {uH, uT, uO}, {v.uh, v.ut, v.uo});
      chk({nm, " sNeg"}, sNeg, v.sn);
      chk({nm, " sDig"}, {sH, sT, sO}, {v.sh, v.st, v.so});
   endtask

   // Accept one operand, check latency and digits, leave DUT in DONE
   task automatic launch(input string nm, input vec_t v);
      int lat;
      chk({nm, " InReady"}, uInReady & sInReady, 1);
      DiffIn   = v.diff;
      BorrowIn = v.borrow;
      InValid  = 1'b1;
      tick();
      InValid = 1'b0;
      chk({nm, " Busy"}, uBusy & sBusy, 1);
      lat = 0;
      while (!uOutValid && lat < 20) begin
         tick();
         lat++;
      end
      chk({nm, " latency"}, lat, 8);
      chk({nm, " sOutValid"}, sOutValid, 1);
      chkOut(nm, v);
   endtask

   task automatic release_out(input string nm);
      OutReady = 1'b1;
      tick();
      OutReady = 1'b0;
      chk({nm, " OutValid drop"}, uOutValid | sOutValid, 0);
      chk({nm, " InReady back"}, uInReady & sInReady, 1);
   endtask

   initial begin
      vec_t hold;
      bit   stable;
      int   edges;

      vecs[0]  = '{8'h2A, 1'b0, 1'b0, 4'hF, 4'h4, 4'h2, 1'b0, 4'hF, 4'h4, 4'h2};
      vecs[1]  = '{8'h01, 1'b1, 1'b1, 4'h2, 4'h5, 4'h5, 1'b0, 4'hF, 4'hF, 4'h1};
      vecs[2]  = '{8'h80, 1'b0, 1'b0, 4'h1, 4'h2, 4'h8, 1'b1, 4'h1, 4'h2, 4'h8};
      vecs[3]  = '{8'h00, 1'b0, 1'b0, 4'hF, 4'hF, 4'h0, 1'b0, 4'hF, 4'hF, 4'h0};
      vecs[4]  = '{8'h00, 1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 1'b0, 4'hF, 4'hF, 4'h0};
      vecs[5]  = '{8'hFF, 1'b0, 1'b0, 4'h2, 4'h5, 4'h5, 1'b1, 4'hF, 4'hF, 4'h1};
      vecs[6]  = '{8'h64, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0};
      vecs[7]  = '{8'h0A, 1'b0, 1'b0, 4'hF, 4'h1, 4'h0, 1'b0, 4'hF, 4'h1, 4'h0};
      vecs[8]  = '{8'h9C, 1'b1, 1'b1, 4'h1, 4'h0, 4'h0, 1'b1, 4'h1, 4'h0, 4'h0};
      vecs[9]  = '{8'hC8, 1'b0, 1'b0, 4'h2, 4'h0, 4'h0, 1'b1, 4'hF, 4'h5, 4'h6};
      vecs[10] = '{8'h7F, 1'b0, 1'b0, 4'h1, 4'h2, 4'h7, 1'b0, 4'h1, 4'h2, 4'h7};
      vecs[11] = '{8'h09, 1'b1, 1'b1, 4'h2, 4'h4, 4'h7, 1'b0, 4'hF, 4'hF, 4'h9};

      rst_n    = 1'b0;
      DiffIn   = 8'h00;
      BorrowIn = 1'b0;
      InValid  = 1'b0;
      OutReady = 1'b0;
      #12;
      chk("reset InReady", uInReady & sInReady, 1);
      chk("reset OutValid", uOutValid | sOutValid, 0);
      chk("reset Busy", uBusy | sBusy, 0);
      chk("reset outputs", {uNeg, uH, uT, uO, sNeg, sH, sT, sO}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      OutReady = 1'b1;
      tick();
      tick();
      OutReady = 1'b0;
      chk("idle OutReady", uOutValid | uBusy, 0);
      chk("idle outputs", {uNeg, uH, uT, uO}, 0);

      for (int i = 0; i < 12; i++) begin
         launch($sformatf("vec%0d", i), vecs[i]);
         release_out($sformatf("vec%0d", i));
         chkOut($sformatf("vec%0d hold", i), vecs[i]);
      end

      // Stall in DONE with a competing operand offered
      hold = vecs[0];
      launch("stall", hold);
      DiffIn   = 8'h33;
      BorrowIn = 1'b1;
      InValid  = 1'b1;
      stable   = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (!uOutValid || !sOutValid || uInReady || sInReady ||
             {uNeg, uH, uT, uO} != {hold.un, hold.uh, hold.ut, hold.uo} ||
             {sNeg, sH, sT, sO} != {hold.sn, hold.sh, hold.st, hold.so})
            stable = 1'b0;
      end
      chk("stall stable", stable, 1);
      InValid = 1'b0;
      release_out("stall");
      chkOut("stall after", hold);

      // Reset at count 4 discards the conversion
      DiffIn   = 8'hFF;
      BorrowIn = 1'b0;
      InValid  = 1'b1;
      tick();
      InValid = 1'b0;
      repeat (4) tick();
      chk("pre-reset Busy", uBusy, 1);
      rst_n = 1'b0;
      #1;
      chk("midreset Busy", uBusy | sBusy, 0);
      chk("midreset InReady", uInReady & sInReady, 1);
      chk("midreset OutValid", uOutValid | sOutValid, 0);
      chk("midreset outputs", {uNeg, uH, uT, uO, sNeg, sH, sT, sO}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      launch("post-reset", vecs[9]);
      release_out("post-reset");

      // Back-to-back with both handshakes held high
      OutReady = 1'b1;
      InValid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         vec_t v;
         v = vecs[(k * 5 + 1) % 12];
         chk($sformatf("b2b%0d ready", k), uInReady, 1);
         DiffIn   = v.diff;
         BorrowIn = v.borrow;
         tick();
         DiffIn = 8'h55;
         edges = 1;
         while (!uOutValid && edges < 30) begin
            tick();
            edges++;
         end
         chkOut($sformatf("b2b%0d", k), v);
         while (!uInReady && edges < 30) begin
            tick();
            edges++;
         end
         chk($sformatf("b2b%0d period", k), edges, 10);
      end
      InValid  = 1'b0;
      OutReady = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
